wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Shares the single register-file write port of the writeback stage between two result producers: requester A (ALU/execute) and requester B (load/long-latency unit).
- Each requester has a small input FIFO with a valid/ready handshake.
- Round-robin arbitration drains the FIFOs into a registered write_addr/write_data/write-enable triple that drives the writeback regfile.
- A per-register pending vector is exported so decode can detect RAW/WAW hazards against writes not yet committed.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register address width; register count NREG = 2**ADDR_W.
- FIFO_DEPTH, 2, entries per requester FIFO; power of two, >= 2.
- DROP_R0, 1, if 1, writes to address 0 are consumed but never issued to the regfile.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, asynchronous active-high reset.
- a_valid, input, 1, requester A has a write.
- a_ready, output, 1, A FIFO can accept.
- a_addr, input, ADDR_W, A destination register.
- a_data, input, DATA_W, A write data.
- b_valid, input, 1, requester B has a write.
- b_ready, output, 1, B FIFO can accept.
- b_addr, input, ADDR_W, B destination register.
- b_data, input, DATA_W, B write data.
- wr_en, output, 1, regfile write strobe (registered).
- wr_addr, output, ADDR_W, regfile write address (registered).
- wr_data, output, DATA_W, regfile write data (registered).
- pending, output, NREG, bit i set while any queued or issuing write targets register i.

Behaviour:
- Reset (async, immediate):
  - Both FIFOs empty; round-robin pointer points at A; wr_en=0, wr_addr=0, wr_data=0; pending=0.
  - a_ready/b_ready=1, but handshakes while rst=1 are ignored.
- Handshake:
  - Push occurs on a posedge where valid && ready. x_ready = (count_x != FIFO_DEPTH), derived from registered count only.
  - A full FIFO shows ready=0 even in a cycle where it pops; no same-cycle pass-through.
  - valid may drop without a handshake; data is sampled only at push.
- Arbitration, evaluated each posedge on registered FIFO state:
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the requester not granted last. The pointer updates on every grant; after reset A wins the first tie.
  - Neither non-empty: no grant; wr_en <= 0 and wr_addr/wr_data hold their values.
- Issue on grant:
  - Pop the head; wr_addr <= head.addr, wr_data <= head.data.
  - wr_en <= 1, except wr_en <= 0 when DROP_R0=1 and head.addr==0.
- Latency: a write pushed at edge k is eligible at edge k+1 at the earliest; wr_en is then high from edge k+1 to edge k+2. Throughput is one issue per cycle total.
- Ordering:
  - FIFO order is preserved per requester.
  - Cross-requester order follows grant order, so same-address writes from A and B commit in grant order.
- pending is combinational from registered state: OR over occupied FIFO entries of decode(addr), OR decode(wr_addr) when wr_en=1. Bit 0 is forced to 0 when DROP_R0=1.
- FIFO pointers wrap modulo FIFO_DEPTH; count has ADDR-independent width clog2(FIFO_DEPTH)+1.
- Reset mid-operation discards all queued writes; no partial issue.

Test Plan:
- Reset: rst asserted between edges with A holding 2 entries and wr_en=1 -> a_ready=1, wr_en=0, pending=0 immediately, before the next edge; no further issues after release.
- Single write: A pushes addr 5, data 0xDEADBEEF at edge k -> pending[5]=1 after edge k; wr_en=1, wr_addr=5, wr_data=0xDEADBEEF for exactly one cycle after edge k+1; pending[5]=0 after edge k+2.
- Fairness: A pushes 1,2,3 and B pushes 11,12,13, both valid from the same edge -> wr_addr sequence 1,11,2,12,3,13 on consecutive cycles, wr_en continuously 1.
- Backpressure: both valid every cycle for 8 cycles -> a_ready/b_ready drop whenever count=2; every accepted entry is issued exactly once, in order, and none are lost.
- DROP_R0=1: A pushes addr 0 then addr 7 -> a single wr_en pulse with wr_addr=7; pending[0] never asserts; both entries leave the FIFO.
- Same-address WAW: A (addr 4, data 1) and B (addr 4, data 2) pushed at the first edge after reset -> A issues first, then B; pending[4] stays high until B's issue cycle ends.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Writeback-port arbiter: two small requester FIFOs (A = execute, B = load unit)
// drained round-robin into one registered regfile write port, plus a
// per-register pending vector for decode-side RAW/WAW hazard detection.
module wb_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int DROP_R0    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [ADDR_W-1:0]       a_addr,
    input  logic [DATA_W-1:0]       a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [ADDR_W-1:0]       b_addr,
    input  logic [DATA_W-1:0]       b_data,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic [(2**ADDR_W)-1:0]  pending
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Which requester received the most recent grant; decides the next tie.
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_grant_t;

    // Index 0 is requester A, index 1 is requester B throughout.
    logic [1:0]         in_valid;
    logic [ADDR_W-1:0]  in_addr [2];
    logic [DATA_W-1:0]  in_data [2];

    logic [ADDR_W-1:0]  q_addr [2][FIFO_DEPTH];
    logic [DATA_W-1:0]  q_data [2][FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr [2];
    logic [PTR_W-1:0]   rptr [2];
    logic [CNT_W-1:0]   count [2];

    logic [1:0]         ready;
    logic [1:0]         push;
    logic [1:0]         nonempty;
    logic [1:0]         grant;
    logic               sel;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    last_grant_t        last_grant;

    assign in_valid   = {b_valid, a_valid};
    assign in_addr[0] = a_addr;
    assign in_addr[1] = b_addr;
    assign in_data[0] = a_data;
    assign in_data[1] = b_data;
    assign a_ready    = ready[0];
    assign b_ready    = ready[1];

    // Ready comes only from the registered count, so a full FIFO stays not-ready even while popping.
    always_comb begin
        ready    = '0;
        push     = '0;
        nonempty = '0;
        for (int i = 0; i < 2; i++) begin
            ready[i]    = (count[i] != FULL_CNT);
            push[i]     = in_valid[i] && ready[i];
            nonempty[i] = (count[i] != '0);
        end
    end

    // Round-robin choice on registered occupancy; on a tie the requester not granted last wins.
    always_comb begin
        grant = 2'b00;
        sel   = 1'b0;
        if (nonempty[0] && nonempty[1]) begin
            sel        = (last_grant == LAST_A);
            grant[sel] = 1'b1;
        end else if (nonempty[0]) begin
            sel      = 1'b0;
            grant[0] = 1'b1;
        end else if (nonempty[1]) begin
            sel      = 1'b1;
            grant[1] = 1'b1;
        end
        head_addr = q_addr[sel][rptr[sel]];
        head_data = q_data[sel][rptr[sel]];
    end

    // FIFO control, round-robin pointer and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
            last_grant <= LAST_B;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wptr[i] <= wptr[i] + PTR_W'(1);
                end
                if (grant[i]) begin
                    rptr[i] <= rptr[i] + PTR_W'(1);
                end
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
            end
            if (grant != 2'b00) begin
                last_grant <= sel ? LAST_B : LAST_A;
                wr_addr    <= head_addr;
                wr_data    <= head_data;
                wr_en      <= !((DROP_R0 != 0) && (head_addr == '0));
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

    // Entry storage needs no reset; the counts alone decide which slots are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                q_addr[i][wptr[i]] <= in_addr[i];
                q_data[i][wptr[i]] <= in_data[i];
            end
        end
    end

    // Pending marks every register targeted by a live FIFO entry or by the write now issuing.
    always_comb begin
        pending = '0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (CNT_W'(k) < count[i]) begin
                    pending[q_addr[i][rptr[i] + PTR_W'(k)]] = 1'b1;
                end
            end
        end
        if (wr_en) begin
            pending[wr_addr] = 1'b1;
        end
        if (DROP_R0 != 0) begin
            pending[0] = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset, single write, fairness,
// backpressure, r0 dropping, same-address ordering and mid-run reset.
module tb_wb_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NREG-1:0]   pending;

    int errors = 0;
    int checks = 0;

    // Per-cycle history sampled on the falling edge, plus stimulus tables.
    logic              hist_en   [32];
    logic [ADDR_W-1:0] hist_addr [32];
    logic [DATA_W-1:0] hist_data [32];
    logic [NREG-1:0]   hist_pend [32];
    logic              hist_ardy [32];
    logic              hist_brdy [32];
    logic [ADDR_W-1:0] tab_a_addr [8];
    logic [DATA_W-1:0] tab_a_data [8];
    logic [ADDR_W-1:0] tab_b_addr [8];
    logic [DATA_W-1:0] tab_b_data [8];
    int a_sent, b_sent;

    wb_write_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(2), .DROP_R0(1)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                                 input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    // Reset for one edge with a dangling handshake offered, release on a falling edge.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd6, 32'h66);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        rst = 1'b0;
    endtask

    // Window c drives the edge after falling edge c; history c shows the edge before it.
    task automatic runTraffic(input int a_lim, input int b_lim, input int win, input int ncyc);
        int ai, bi;
        a_sent = 0;
        b_sent = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            hist_en[c]   = wr_en;
            hist_addr[c] = wr_addr;
            hist_data[c] = wr_data;
            hist_pend[c] = pending;
            hist_ardy[c] = a_ready;
            hist_brdy[c] = b_ready;
            ai = (a_sent < 8) ? a_sent : 7;
            bi = (b_sent < 8) ? b_sent : 7;
            applyStimulus((c < win) && (a_sent < a_lim), tab_a_addr[ai], tab_a_data[ai],
                          (c < win) && (b_sent < b_lim), tab_b_addr[bi], tab_b_data[bi]);
            if (a_valid && a_ready) a_sent++;
            if (b_valid && b_ready) b_sent++;
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic loadFairTables();
        for (int n = 0; n < 8; n++) begin
            tab_a_addr[n] = ADDR_W'(1 + n);
            tab_a_data[n] = 32'h100 + 32'(1 + n);
            tab_b_addr[n] = ADDR_W'(11 + n);
            tab_b_data[n] = 32'h100 + 32'(11 + n);
        end
    endtask

    initial begin
        int fair_exp [6];
        int en_total;
        logic pend0_seen;
        fair_exp = '{1, 11, 2, 12, 3, 13};
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

        // Reset state, and handshakes offered during reset are ignored.
        @(negedge clk);
        checkOutput("rst_a_ready", a_ready, 1);
        checkOutput("rst_b_ready", b_ready, 1);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_pending", pending, 0);
        doReset();
        runTraffic(0, 0, 0, 4);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("rst_ignore_en%0d", c), hist_en[c], 0);
            checkOutput($sformatf("rst_ignore_pend%0d", c), hist_pend[c], 0);
        end

        // Single write from A.
        doReset();
        tab_a_addr[0] = 5'd5;
        tab_a_data[0] = 32'hDEADBEEF;
        runTraffic(1, 0, 1, 5);
        checkOutput("single_pend_q", hist_pend[1], 32'h20);
        checkOutput("single_en_q", hist_en[1], 0);
        checkOutput("single_en", hist_en[2], 1);
        checkOutput("single_addr", hist_addr[2], 5);
        checkOutput("single_data", hist_data[2], 32'hDEADBEEF);
        checkOutput("single_pend_iss", hist_pend[2], 32'h20);
        checkOutput("single_en_off", hist_en[3], 0);
        checkOutput("single_pend_off", hist_pend[3], 0);
        checkOutput("single_addr_hold", hist_addr[3], 5);

        // Fairness: alternating grants, back-to-back strobes.
        doReset();
        loadFairTables();
        runTraffic(3, 3, 8, 10);
        checkOutput("fair_en_pre", hist_en[1], 0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("fair_en%0d", i), hist_en[2 + i], 1);
            checkOutput($sformatf("fair_addr%0d", i), hist_addr[2 + i], 64'(fair_exp[i]));
            checkOutput($sformatf("fair_data%0d", i), hist_data[2 + i], 64'(32'h100 + 32'(fair_exp[i])));
        end
        checkOutput("fair_en_post", hist_en[8], 0);

        // Backpressure: both valid for 8 windows.
        doReset();
        for (int n = 0; n < 8; n++) begin
            tab_a_addr[n] = ADDR_W'(8 + n);
            tab_a_data[n] = 32'hA000_0000 + 32'(n);
            tab_b_addr[n] = ADDR_W'(20 + n);
            tab_b_data[n] = 32'hB000_0000 + 32'(n);
        end
        runTraffic(8, 8, 8, 16);
        checkOutput("bp_a_ready_pat",
                    {hist_ardy[0], hist_ardy[1], hist_ardy[2], hist_ardy[3],
                     hist_ardy[4], hist_ardy[5], hist_ardy[6], hist_ardy[7]}, 8'b1110_1010);
        checkOutput("bp_b_ready_pat",
                    {hist_brdy[0], hist_brdy[1], hist_brdy[2], hist_brdy[3],
                     hist_brdy[4], hist_brdy[5], hist_brdy[6], hist_brdy[7]}, 8'b1101_0101);
        checkOutput("bp_a_accepted", 64'(a_sent), 5);
        checkOutput("bp_b_accepted", 64'(b_sent), 5);
        for (int n = 0; n < 5; n++) begin
            checkOutput($sformatf("bp_a_addr%0d", n), hist_addr[2 + 2 * n], 64'(8 + n));
            checkOutput($sformatf("bp_a_data%0d", n), hist_data[2 + 2 * n], 64'(32'hA000_0000 + 32'(n)));
            checkOutput($sformatf("bp_b_addr%0d", n), hist_addr[3 + 2 * n], 64'(20 + n));
            checkOutput($sformatf("bp_b_data%0d", n), hist_data[3 + 2 * n], 64'(32'hB000_0000 + 32'(n)));
        end
        en_total = 0;
        for (int c = 0; c < 16; c++) begin
            if (hist_en[c]) en_total++;
        end
        checkOutput("bp_issue_count", 64'(en_total), 10);
        checkOutput("bp_pend_end", hist_pend[15], 0);

        // Writes to r0 are consumed silently.
        doReset();
        tab_a_addr[0] = 5'd0;
        tab_a_data[0] = 32'h55;
        tab_a_addr[1] = 5'd7;
        tab_a_data[1] = 32'h77;
        runTraffic(2, 0, 8, 6);
        pend0_seen = 1'b0;
        en_total = 0;
        for (int c = 0; c < 6; c++) begin
            pend0_seen = pend0_seen | hist_pend[c][0];
            if (hist_en[c]) en_total++;
        end
        checkOutput("r0_pend0_never", pend0_seen, 0);
        checkOutput("r0_pend_q", hist_pend[1], 0);
        checkOutput("r0_drop_en", hist_en[2], 0);
        checkOutput("r0_drop_addr", hist_addr[2], 0);
        checkOutput("r0_pend7", hist_pend[2], 32'h80);
        checkOutput("r0_issue_en", hist_en[3], 1);
        checkOutput("r0_issue_addr", hist_addr[3], 7);
        checkOutput("r0_issue_data", hist_data[3], 32'h77);
        checkOutput("r0_pulse_count", 64'(en_total), 1);
        checkOutput("r0_pend_end", hist_pend[4], 0);

        // Same-address writes commit in grant order.
        doReset();
        tab_a_addr[0] = 5'd4;
        tab_a_data[0] = 32'd1;
        tab_b_addr[0] = 5'd4;
        tab_b_data[0] = 32'd2;
        runTraffic(1, 1, 1, 6);
        checkOutput("waw_pend_q", hist_pend[1], 32'h10);
        checkOutput("waw_first_en", hist_en[2], 1);
        checkOutput("waw_first_data", hist_data[2], 1);
        checkOutput("waw_pend_mid", hist_pend[2], 32'h10);
        checkOutput("waw_second_en", hist_en[3], 1);
        checkOutput("waw_second_data", hist_data[3], 2);
        checkOutput("waw_pend_last", hist_pend[3], 32'h10);
        checkOutput("waw_pend_end", hist_pend[4], 0);

        // Asynchronous reset while A is full and a write is issuing.
        doReset();
        loadFairTables();
        runTraffic(3, 3, 8, 4);
        checkOutput("mid_pre_en", hist_en[3], 1);
        checkOutput("mid_pre_ardy", hist_ardy[3], 0);
        checkOutput("mid_pre_addr", hist_addr[3], 11);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_ardy", a_ready, 1);
        checkOutput("mid_rst_en", wr_en, 0);
        checkOutput("mid_rst_pend", pending, 0);
        @(negedge clk);
        rst = 1'b0;
        runTraffic(0, 0, 0, 5);
        en_total = 0;
        for (int c = 0; c < 5; c++) begin
            if (hist_en[c]) en_total++;
        end
        checkOutput("mid_after_issues", 64'(en_total), 0);
        checkOutput("mid_after_pend", hist_pend[4], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
